// File: rtl/jtag_soc_cfg_bridge.sv
// ---------------------------------------------------------------------------
// jtag_soc_cfg_bridge
//
// Purpose:
//   SoC-side consumer of the quasi-static JTAG configuration register.
//   The TCK-domain value is brought into the SoC clock domain with a two-flop
//   synchronizer. A new value is accepted only after it has held stable for
//   STABLE_CYCLES synchronized samples and differs from the last accepted
//   value. Each accepted value is delivered once through a 2-entry
//   valid/ready queue. A registered copy of the SoC status byte is returned
//   toward the TAP side.
//
// Ports:
//   clk_i          in   SoC clock (only clock)
//   rst_ni         in   synchronous active-low reset
//   jtag_cfg_i     in   config byte from the TCK domain (asynchronous)
//   cfg_o          out  head-of-queue accepted value
//   cfg_valid_o    out  queue non-empty
//   cfg_ready_i    in   consumer pops the head when high with cfg_valid_o
//   overrun_o      out  sticky: an accepted value was dropped (queue full)
//   clr_overrun_i  in   clears overrun_o (a same-cycle set wins)
//   status_i       in   SoC status to report to JTAG
//   jtag_status_o  out  registered status_i for the TAP-side synchronizer
// ---------------------------------------------------------------------------
module jtag_soc_cfg_bridge #(
   parameter int               WIDTH         = 8,
   parameter int               STABLE_CYCLES = 4,
   parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] jtag_cfg_i,
   output logic [WIDTH-1:0] cfg_o,
   output logic             cfg_valid_o,
   input  logic             cfg_ready_i,
   output logic             overrun_o,
   input  logic             clr_overrun_i,
   input  logic [WIDTH-1:0] status_i,
   output logic [WIDTH-1:0] jtag_status_o
);

   localparam logic [7:0] CntMax = 8'(STABLE_CYCLES - 1);

   logic [WIDTH-1:0] sync1_q;
   logic [WIDTH-1:0] sync2_q;
   logic [WIDTH-1:0] cand_q;
   logic [WIDTH-1:0] cand_d;
   logic [7:0]       cnt_q;
   logic [7:0]       cnt_d;
   logic [WIDTH-1:0] last_q;

   logic [WIDTH-1:0] mem_q [2];
   logic             rdPtr_q;
   logic             wrPtr_q;
   logic [1:0]       count_q;
   logic             overrun_q;
   logic [WIDTH-1:0] status_q;

   logic accept;
   logic pop;
   logic full;
   logic pushOk;

   // Two-flop synchronizer. Only sync2_q is used by anything downstream, so
   // the first flop is free to go metastable without corrupting the filter.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sync1_q <= RESET_VAL;
         sync2_q <= RESET_VAL;
      end else begin
         sync1_q <= jtag_cfg_i;
         sync2_q <= sync1_q;
      end
   end

   // Stability filter next state: any change of the synchronized value
   // restarts qualification; otherwise the counter saturates at CntMax so
   // that a long-held value keeps the accept condition armed without wrap.
   always_comb begin
      cand_d = cand_q;
      cnt_d  = cnt_q;
      if (sync2_q != cand_q) begin
         cand_d = sync2_q;
         cnt_d  = '0;
      end else if (cnt_q < CntMax) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   // Accept is naturally single-cycle: once last_q takes the candidate the
   // inequality drops. A value that comes back to last_q never re-fires.
   assign accept = (sync2_q == cand_q) && (cnt_q == CntMax) && (cand_q != last_q);
   assign full   = (count_q == 2'd2);
   assign pop    = (count_q != 2'd0) && cfg_ready_i;
   assign pushOk = accept && (!full || pop);

   // Candidate, counter and last-accepted registers. last_q is updated on
   // every accept, even when the queue drops the value, so a dropped value
   // is not re-offered later.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cand_q <= RESET_VAL;
         cnt_q  <= '0;
         last_q <= RESET_VAL;
      end else begin
         cand_q <= cand_d;
         cnt_q  <= cnt_d;
         if (accept) begin
            last_q <= cand_q;
         end
      end
   end

   // Two-entry circular queue. On push+pop while full the write slot equals
   // the head being popped, so overwriting it is safe and the old second
   // entry becomes the new head with no bubble.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         mem_q[0]  <= '0;
         mem_q[1]  <= '0;
         rdPtr_q   <= 1'b0;
         wrPtr_q   <= 1'b0;
         count_q   <= 2'd0;
         overrun_q <= 1'b0;
      end else begin
         if (pushOk) begin
            mem_q[wrPtr_q] <= cand_q;
            wrPtr_q        <= ~wrPtr_q;
         end
         if (pop) begin
            rdPtr_q <= ~rdPtr_q;
         end
         unique case ({pushOk, pop})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
         if (accept && full && !pop) begin
            overrun_q <= 1'b1;
         end else if (clr_overrun_i) begin
            overrun_q <= 1'b0;
         end
      end
   end

   // Status is simply re-registered; the TAP side resynchronizes it.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         status_q <= '0;
      end else begin
         status_q <= status_i;
      end
   end

   assign cfg_o         = mem_q[rdPtr_q];
   assign cfg_valid_o   = (count_q != 2'd0);
   assign overrun_o     = overrun_q;
   assign jtag_status_o = status_q;

endmodule

// File: tb/tb_jtag_soc_cfg_bridge.sv
// ---------------------------------------------------------------------------
// tb_jtag_soc_cfg_bridge
//
// Drives directed scenarios (reset default, clean change, glitch pulses,
// overrun, coincident push/pop and set/clear, mid-operation reset) followed
// by randomized traffic, and compares every cycle against a reference model
// that tracks how long the synchronized value has been unchanged and keeps
// the delivered values in a plain queue.
// ---------------------------------------------------------------------------
module tb_jtag_soc_cfg_bridge;

   localparam int S = 4;

   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic [7:0] jtag_cfg_i;
   logic [7:0] cfg_o;
   logic       cfg_valid_o;
   logic       cfg_ready_i;
   logic       overrun_o;
   logic       clr_overrun_i;
   logic [7:0] status_i;
   logic [7:0] jtag_status_o;

   int totalChecks = 0;
   int badChecks   = 0;

   // Reference model state
   logic [7:0] mS1;
   logic [7:0] mV;
   int         mRun;
   logic [7:0] mLast;
   logic [7:0] mQ[$];
   logic       mOverrun;
   logic [7:0] mStatus;
   bit         mInit      = 0;
   bit         mJustReset = 0;
   bit         randStatus = 0;

   jtag_soc_cfg_bridge #(
      .WIDTH(8),
      .STABLE_CYCLES(S),
      .RESET_VAL(8'h00)
   ) dut (
      .clk_i(clk_i),
      .rst_ni(rst_ni),
      .jtag_cfg_i(jtag_cfg_i),
      .cfg_o(cfg_o),
      .cfg_valid_o(cfg_valid_o),
      .cfg_ready_i(cfg_ready_i),
      .overrun_o(overrun_o),
      .clr_overrun_i(clr_overrun_i),
      .status_i(status_i),
      .jtag_status_o(jtag_status_o)
   );

   always #5 clk_i = ~clk_i;

   // Counts one comparison and reports it when observed and expected differ.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      totalChecks++;
      if (observed !== expected) begin
         badChecks++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Reference behaviour for one clock edge. A value is accepted once the
   // synchronized input has shown the same value on S+1 consecutive edges
   // (one edge to load the candidate, S-1 to count up, one to present it)
   // and differs from the last accepted one.
   task automatic modelEdge();
      bit acc;
      bit pop;
      bit dropped;
      if (!rst_ni) begin
         mS1        = 8'h00;
         mV         = 8'h00;
         mRun       = 2;
         mLast      = 8'h00;
         mQ.delete();
         mOverrun   = 1'b0;
         mStatus    = 8'h00;
         mInit      = 1;
         mJustReset = 1;
      end else begin
         acc     = (mRun >= S + 1) && (mV != mLast);
         pop     = (mQ.size() != 0) && cfg_ready_i;
         dropped = 0;
         if (pop) void'(mQ.pop_front());
         if (acc) begin
            mLast = mV;
            if (mQ.size() < 2) mQ.push_back(mV);
            else dropped = 1;
         end
         if (dropped) mOverrun = 1'b1;
         else if (clr_overrun_i) mOverrun = 1'b0;
         mStatus = status_i;
         if (mS1 == mV) begin
            if (mRun < 1000) mRun++;
         end else begin
            mRun = 1;
         end
         mV         = mS1;
         mS1        = jtag_cfg_i;
         mJustReset = 0;
      end
   endtask

   // One clock: update the model at the edge, compare 1 time unit later.
   task automatic tick();
      @(posedge clk_i);
      modelEdge();
      #1;
      if (mInit) begin
         checkOutput("valid", cfg_valid_o, (mQ.size() != 0));
         if (mQ.size() != 0) checkOutput("head", cfg_o, mQ[0]);
         else if (mJustReset) checkOutput("headRst", cfg_o, 8'h00);
         checkOutput("overrun", overrun_o, mOverrun);
         checkOutput("status", jtag_status_o, mStatus);
      end
      if (randStatus) status_i = 8'($urandom);
   endtask

   // Sets the inputs and runs the given number of clocks.
   task automatic applyStimulus(input logic [7:0] cfg, input logic ready,
                                input logic clr, input int cycles);
      jtag_cfg_i    = cfg;
      cfg_ready_i   = ready;
      clr_overrun_i = clr;
      for (int i = 0; i < cycles; i++) tick();
   endtask

   task automatic doReset(input int cycles);
      rst_ni = 1'b0;
      for (int i = 0; i < cycles; i++) tick();
      rst_ni = 1'b1;
   endtask

   initial begin
      rst_ni        = 1'b0;
      jtag_cfg_i    = 8'h00;
      cfg_ready_i   = 1'b0;
      clr_overrun_i = 1'b0;
      status_i      = 8'h00;
      #2;
      doReset(2);

      // Reset default
      applyStimulus(8'h00, 1'b0, 1'b0, 20);

      // Clean change with consumer always ready
      applyStimulus(8'h5A, 1'b1, 1'b0, 12);
      applyStimulus(8'h00, 1'b1, 1'b0, 12);

      // Glitch pulses of 3, 4 and 5 cycles, each followed by a return to 0x00
      for (int len = 3; len <= 5; len++) begin
         applyStimulus(8'h33, 1'b1, 1'b0, len);
         applyStimulus(8'h00, 1'b1, 1'b0, 12);
      end

      // Queue full and overrun, then drain and clear
      applyStimulus(8'h11, 1'b0, 1'b0, 10);
      applyStimulus(8'h22, 1'b0, 1'b0, 10);
      applyStimulus(8'h33, 1'b0, 1'b0, 10);
      applyStimulus(8'h33, 1'b1, 1'b0, 4);
      applyStimulus(8'h33, 1'b0, 1'b1, 1);
      applyStimulus(8'h33, 1'b0, 1'b0, 2);

      // Full queue: push and pop coincide on the 7th edge
      applyStimulus(8'h44, 1'b0, 1'b0, 10);
      applyStimulus(8'h55, 1'b0, 1'b0, 10);
      applyStimulus(8'h66, 1'b0, 1'b0, 6);
      applyStimulus(8'h66, 1'b1, 1'b0, 1);
      applyStimulus(8'h66, 1'b0, 1'b0, 4);

      // Full queue: overrun set coincides with clear request
      applyStimulus(8'h77, 1'b0, 1'b0, 6);
      applyStimulus(8'h77, 1'b0, 1'b1, 1);
      applyStimulus(8'h77, 1'b0, 1'b0, 3);
      applyStimulus(8'h77, 1'b1, 1'b1, 4);

      // Mid-operation reset with two queued entries and a half-qualified value
      applyStimulus(8'h11, 1'b0, 1'b0, 10);
      applyStimulus(8'h33, 1'b0, 1'b0, 10);
      applyStimulus(8'h22, 1'b0, 1'b0, 4);
      doReset(1);
      applyStimulus(8'h22, 1'b1, 1'b0, 12);

      // Randomized traffic
      randStatus = 1;
      for (int n = 0; n < 400; n++) begin
         logic [7:0] vals [4];
         vals[0] = 8'h00; vals[1] = 8'hA5; vals[2] = 8'h3C; vals[3] = 8'hFF;
         if ($urandom_range(0, 49) == 0) doReset(1);
         applyStimulus(vals[$urandom_range(0, 3)], 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 7) == 0), int'($urandom_range(1, 10)));
      end

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
